xadc_drp_scheduler: RTL and testbench

// - Owns the XADC DRP port; shares it between two requesters: the XADC conversion stream (eoc) and a user read port.
// - On each eoc rising edge: reads the result register of the converted channel, stores the 12-bit code per aux slot and emits a sample strobe.
// - User port: reads any DRP address (status or config) when no conversion read is due. Sits between xadc_wiz_0 and display/processing logic.

---
 rtl/xadc_drp_scheduler_pkg.sv | 24 ++
 rtl/edge_detector_n.sv | 20 ++
 rtl/xadc_drp_scheduler.sv | 166 ++++++++++++++++
 tb/tb_xadc_drp_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_scheduler_pkg.sv
// Shared DRP address map and FSM encodings for the XADC DRP scheduler.
package xadc_drp_scheduler_pkg;

  localparam logic [6:0] ADDR_TEMP   = 7'h00;
  localparam logic [6:0] ADDR_VCCINT = 7'h01;
  localparam logic [6:0] ADDR_AUX0   = 7'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    SRC_CONV = 1'b0,
    SRC_USER = 1'b1
  } src_t;

  // True when addr is the result register of one of the nch stored aux slots.
  function automatic logic is_aux(input logic [6:0] addr, input int nch);
    return (int'(addr) >= int'(ADDR_AUX0)) && (int'(addr) < int'(ADDR_AUX0) + nch);
  endfunction

endpackage

// File: rtl/edge_detector_n.sv
// N-bit rising-edge detector: one register stage, p_edge high for the first cycle a bit is seen high.
module edge_detector_n #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] din,
  output logic [N-1:0] p_edge
);

  logic [N-1:0] din_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_d <= '0;
    else       din_d <= din;
  end

  assign p_edge = din & ~din_d;

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Owns the XADC DRP port: services conversion-result reads on eoc and user reads,
// one transaction at a time, conversions first.
module xadc_drp_scheduler
  import xadc_drp_scheduler_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int TIMEOUT = 255,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              eoc,
  input  logic [4:0]        channel,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [6:0]        drp_daddr,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  input  logic              req,
  input  logic [6:0]        req_addr,
  output logic              ack,
  output logic [15:0]       rdata,
  output logic              sample_vld,
  output logic [SW-1:0]     sample_slot,
  output logic [12*NCH-1:0] values,
  output logic [NCH-1:0]    valid,
  output logic              overrun,
  output logic              timeout
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  src_t          src;
  logic          eoc_edge;
  logic          pend;
  logic [4:0]    pend_ch;
  logic [7:0]    tmo;
  logic          take_conv, take_user, drdy_hit, tmo_hit;
  logic          conv_hit, user_hit;
  logic [SW-1:0] slot;

  edge_detector_n #(.N(1)) u_eoc_edge (
    .clk    (clk),
    .rstn   (rstn),
    .din    (eoc),
    .p_edge (eoc_edge)
  );

  assign drp_dwe = 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    drp_den   = 1'b0;
    take_conv = 1'b0;
    take_user = 1'b0;
    drdy_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          take_conv = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (req) begin
          take_user = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        drp_den   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          drdy_hit  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-entry mailbox for conversions; an edge landing on the consume cycle re-arms it cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend    <= 1'b0;
      pend_ch <= '0;
      overrun <= 1'b0;
    end else if (eoc_edge) begin
      pend    <= 1'b1;
      pend_ch <= channel;
      if (pend && !take_conv) overrun <= 1'b1;
    end else if (take_conv) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drp_daddr <= '0;
      src       <= SRC_CONV;
    end else if (take_conv) begin
      drp_daddr <= {2'b00, pend_ch};
      src       <= SRC_CONV;
    end else if (take_user) begin
      drp_daddr <= req_addr;
      src       <= SRC_USER;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     tmo <= '0;
      else if (state == ST_WAIT) tmo <= tmo + 8'd1;
      if (tmo_hit) timeout <= 1'b1;
    end
  end

  assign conv_hit = drdy_hit && (src == SRC_CONV) && is_aux(drp_daddr, NCH);
  assign user_hit = drdy_hit && (src == SRC_USER);
  assign slot     = SW'(drp_daddr - ADDR_AUX0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack         <= 1'b0;
      rdata       <= '0;
      sample_vld  <= 1'b0;
      sample_slot <= '0;
    end else begin
      ack        <= user_hit;
      sample_vld <= conv_hit;
      if (user_hit) rdata       <= drp_do;
      if (conv_hit) sample_slot <= slot;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    logic [11:0] code;
    logic        seen;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        code <= '0;
        seen <= 1'b0;
      end else if (conv_hit && slot == SW'(k)) begin
        code <= drp_do[15:4];
        seen <= 1'b1;
      end
    end

    assign values[12*k +: 12] = code;
    assign valid[k]           = seen;
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: directed scenarios plus a random phase, all checked
// against an event-level model (edge list, one-deep mailbox, per-slot code table).
module tb_xadc_drp_scheduler;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              eoc = 1'b0;
  logic [4:0]        channel = '0;
  logic              drp_den, drp_dwe;
  logic [6:0]        drp_daddr;
  logic [15:0]       drp_do = '0;
  logic              drp_drdy = 1'b0;
  logic              req = 1'b0;
  logic [6:0]        req_addr = '0;
  logic              ack;
  logic [15:0]       rdata;
  logic              sample_vld;
  logic [1:0]        sample_slot;
  logic [12*NCH-1:0] values;
  logic [NCH-1:0]    valid;
  logic              overrun, timeout;

  xadc_drp_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .eoc(eoc), .channel(channel),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .req(req), .req_addr(req_addr), .ack(ack), .rdata(rdata),
    .sample_vld(sample_vld), .sample_slot(sample_slot),
    .values(values), .valid(valid), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [4:0] ch;
  } ev_t;

  ev_t          evq[$];
  logic [6:0]   den_log[$];
  logic [11:0]  m_val[NCH];
  logic [NCH-1:0] m_vld = '0;
  bit           m_ovr = 0;
  bit           busy = 0, inf_conv = 0, dropped = 0, eoc_prev = 0;
  bit           no_resp = 0, rand_en = 0, late_drdy = 0, fdata_en = 0;
  logic [6:0]   inf_addr = '0, eaddr;
  logic [4:0]   lastch;
  logic [15:0]  rdat = '0, fdata = '0;
  int           drdy_at = -1, res_at = -1, den_cyc = 0, den_cnt = 0, dly_fix = 0;
  int           s, cnt, d;

  function automatic logic [12*NCH-1:0] pack_vals();
    logic [12*NCH-1:0] p;
    for (int k = 0; k < NCH; k++) p[12*k +: 12] = m_val[k];
    return p;
  endfunction

  task automatic model_clear();
    evq.delete();
    for (int k = 0; k < NCH; k++) m_val[k] = '0;
    m_vld    = '0;
    m_ovr    = 0;
    busy     = 0;
    drdy_at  = -1;
    res_at   = -1;
    eoc_prev = 0;
    drp_drdy = 1'b0;
  endtask

  // DRP responder, requester ack handling and model update, once per cycle on the falling edge.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        model_clear();
        continue;
      end
      if (res_at == cyc) begin
        res_at = -1;
        busy   = 0;
        if (inf_conv && int'(inf_addr) >= 16 && int'(inf_addr) < 16 + NCH) begin
          s = int'(inf_addr) - 16;
          m_val[s] = rdat[15:4];
          m_vld[s] = 1'b1;
          chk("sample_vld", sample_vld, 1);
          chk("sample_slot", sample_slot, 64'(s));
          chk("ack_on_conv", ack, 0);
        end else if (inf_conv) begin
          chk("sample_vld_offslot", sample_vld, 0);
          chk("ack_on_conv", ack, 0);
        end else begin
          chk("ack", ack, 1);
          chk("rdata", rdata, rdat);
          chk("sample_vld_on_user", sample_vld, 0);
          req     = 1'b0;
          dropped = 1;
        end
        chk("values", values, pack_vals());
        chk("valid", valid, m_vld);
      end else begin
        chk("no_pulse", {sample_vld, ack}, 0);
      end

      if (drp_den) begin
        den_cyc = cyc;
        den_cnt++;
        chk("den_while_busy", busy, 0);
        cnt = 0;
        while (evq.size() > 0 && evq[0].idx <= cyc - 1) begin
          lastch = evq[0].ch;
          void'(evq.pop_front());
          cnt++;
        end
        if (cnt > 0) begin
          if (cnt > 1) m_ovr = 1;
          eaddr    = {2'b00, lastch};
          inf_conv = 1;
        end else begin
          eaddr    = req_addr;
          inf_conv = 0;
          chk("user_read_without_req", req, 1);
        end
        inf_addr = eaddr;
        den_log.push_back(eaddr);
        chk("daddr", drp_daddr, eaddr);
        chk("overrun", overrun, m_ovr);
        chk("dwe", drp_dwe, 0);
        if (!no_resp) begin
          busy    = 1;
          d       = (dly_fix > 0) ? dly_fix : int'($urandom_range(1, 4));
          drdy_at = cyc + d;
          res_at  = cyc + d + 1;
          rdat    = fdata_en ? fdata : 16'($urandom);
        end
      end

      drp_drdy  = (cyc == drdy_at) || late_drdy;
      drp_do    = late_drdy ? 16'hFFFF : (drp_drdy ? rdat : 16'h0000);
      late_drdy = 0;

      if (eoc && !eoc_prev) evq.push_back('{cyc + 1, channel});
      eoc_prev = eoc;

      if (rand_en && !req && !dropped && $urandom_range(0, 7) == 0) begin
        req_addr = 7'($urandom);
        req      = 1'b1;
      end
      dropped = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_eoc(input logic [4:0] ch);
    eoc     = 1'b1;
    channel = ch;
    step();
    eoc = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (!busy && evq.size() == 0 && !req && !eoc && !drp_den) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    chk("idle_wait_expired", 0, 1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"}, {drp_den, drp_dwe, ack, sample_vld, sample_slot, overrun, timeout, valid, drp_daddr}, 0);
    chk({tag, "_values"}, values, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int t0, n0, c0;

  initial begin
    repeat (3) step();
    @(negedge clk);
    rst_chk("reset");
    step();
    rstn = 1'b1;
    step();

    // Conversion on VAUX0 with a fixed 3-cycle DRP response.
    fdata_en = 1; fdata = 16'hABC0; dly_fix = 3;
    t0 = cyc;
    pulse_eoc(5'd16);
    wait_idle();
    chk("t1_den_latency", 64'(den_cyc - t0), 2);
    chk("t1_addr", den_log[den_log.size()-1], 7'h10);
    chk("t1_code", values[11:0], 12'hABC);
    chk("t1_valid", valid, 4'b0001);

    // Plain user read of the temperature register.
    fdata = 16'h9A50;
    req_addr = 7'h00; req = 1'b1;
    wait_idle();
    chk("t2_rdata", rdata, 16'h9A50);
    chk("t2_values_kept", values[11:0], 12'hABC);
    chk("t2_addr", den_log[den_log.size()-1], 7'h00);

    // Pending conversion and held request meet in IDLE: conversion wins.
    fdata_en = 0; dly_fix = 0;
    n0 = den_log.size();
    pulse_eoc(5'd17);
    req_addr = 7'h01; req = 1'b1;
    wait_idle();
    chk("t3_reads", 64'(den_log.size() - n0), 2);
    if (den_log.size() - n0 == 2) begin
      chk("t3_first", den_log[n0], 7'h11);
      chk("t3_second", den_log[n0+1], 7'h01);
    end
    chk("t3_valid", valid, 4'b0011);

    // Channel outside the aux window is read but not stored.
    pulse_eoc(5'd3);
    wait_idle();
    chk("t6_addr", den_log[den_log.size()-1], 7'h03);
    chk("t6_valid", valid, 4'b0011);

    // Random traffic on both requesters.
    rand_en = 1;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (eoc) eoc = 1'b0;
      else if ($urandom_range(0, 4) == 0) begin
        eoc = 1'b1;
        case ($urandom_range(0, 5))
          0: channel = 5'd3;
          1: channel = 5'd20;
          default: channel = 5'(16 + $urandom_range(0, 3));
        endcase
      end
    end
    rand_en = 0;
    eoc = 1'b0;
    wait_idle();
    chk("rand_overrun", overrun, m_ovr);
    chk("rand_valid", valid, m_vld);
    chk("rand_values", values, pack_vals());

    // Reset while a read is outstanding; a drdy after reset must be ignored.
    no_resp = 1;
    c0 = den_cnt;
    pulse_eoc(5'd16);
    for (int k = 0; k < 10 && den_cnt == c0; k++) step();
    chk("rst_den_seen", den_cnt != c0, 1);
    step(); step();
    rstn = 1'b0;
    @(negedge clk);
    rst_chk("midwait_reset");
    step();
    rstn = 1'b1;
    no_resp = 0;
    late_drdy = 1;
    repeat (3) step();
    rst_chk("late_drdy");

    // Two edges while a read is in WAIT: only the newest is serviced, overrun set.
    dly_fix = 4;
    n0 = den_log.size();
    pulse_eoc(5'd19);
    step();
    pulse_eoc(5'd16);
    step();
    pulse_eoc(5'd18);
    wait_idle();
    dly_fix = 0;
    chk("t4_overrun", overrun, 1);
    chk("t4_reads", 64'(den_log.size() - n0), 2);
    if (den_log.size() - n0 == 2) begin
      chk("t4_first", den_log[n0], 7'h13);
      chk("t4_second", den_log[n0+1], 7'h12);
    end
    chk("t4_valid", valid, 4'b1100);

    // DRP never answers: timeout after TIMEOUT cycles in WAIT, then normal service.
    no_resp = 1;
    c0 = den_cnt;
    pulse_eoc(5'd17);
    for (int k = 0; k < 10 && den_cnt == c0; k++) step();
    chk("t5_den_seen", den_cnt != c0, 1);
    if (den_cnt != c0) begin
      while (cyc < den_cyc + TIMEOUT) step();
      @(negedge clk);
      chk("t5_timeout_early", timeout, 0);
      @(negedge clk);
      chk("t5_timeout", timeout, 1);
    end
    no_resp = 0;
    step();
    pulse_eoc(5'd17);
    wait_idle();
    chk("t5_after_valid", valid, 4'b1110);
    chk("t5_timeout_sticky", timeout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
